// File: rtl/reg_writeback_unit_pkg.sv
// Shared types and widths for the register writeback unit.
package reg_writeback_unit_pkg;

    localparam int NUM_REGISTERS = 16;
    localparam int SEL_WIDTH     = 4;
    localparam int DATA_WIDTH    = 32;
    localparam int WB_FIFO_DEPTH = 4;

    typedef logic [SEL_WIDTH-1:0]  sel_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    // One buffered result heading for the register file.
    typedef struct packed {
        sel_t  sel;
        data_t data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_ALU    = 2'd0,
        SRC_MEM    = 2'd1,
        SRC_MULDIV = 2'd2
    } wb_source_e;

    // True when the write port is committing to register sel this cycle.
    function automatic logic write_hits(logic we, sel_t ws, sel_t s);
        return we && (ws == s);
    endfunction

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Handshake, scoreboard and write-port signals of the writeback unit.
interface reg_writeback_unit_if;

    logic                              reserve_en;
    reg_writeback_unit_pkg::sel_t      reserve_sel;
    logic                              reserve_ok;

    logic                              alu_valid, mem_valid, md_valid;
    logic                              alu_ready, mem_ready, md_ready;
    reg_writeback_unit_pkg::sel_t      alu_sel, mem_sel, md_sel;
    reg_writeback_unit_pkg::data_t     alu_data, mem_data, md_data;

    logic                              wb_hold;

    reg_writeback_unit_pkg::sel_t      query_sel_ra, query_sel_rb, query_sel_rc;
    logic                              busy_ra, busy_rb, busy_rc;

    logic                              write_en;
    reg_writeback_unit_pkg::sel_t      write_sel;
    reg_writeback_unit_pkg::data_t     write_data;

    // Producer/decode side driving the unit.
    modport master (
        output reserve_en, reserve_sel,
        input  reserve_ok,
        output alu_valid, mem_valid, md_valid,
        input  alu_ready, mem_ready, md_ready,
        output alu_sel, mem_sel, md_sel, alu_data, mem_data, md_data,
        output wb_hold,
        output query_sel_ra, query_sel_rb, query_sel_rc,
        input  busy_ra, busy_rb, busy_rc,
        input  write_en, write_sel, write_data
    );

    // The writeback unit itself.
    modport slave (
        input  reserve_en, reserve_sel,
        output reserve_ok,
        input  alu_valid, mem_valid, md_valid,
        output alu_ready, mem_ready, md_ready,
        input  alu_sel, mem_sel, md_sel, alu_data, mem_data, md_data,
        input  wb_hold,
        input  query_sel_ra, query_sel_rb, query_sel_rc,
        output busy_ra, busy_rb, busy_rc,
        output write_en, write_sel, write_data
    );

endinterface

// File: rtl/reg_writeback_unit_wb_fifo.sv
// Small synchronous FIFO of writeback entries, count-based occupancy.
module wb_fifo
    import reg_writeback_unit_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write port producer: arbitrates three result sources into a
// FIFO, issues one registered write per cycle, and tracks pending registers.
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_writeback_unit_if.slave  bus
);

    logic                     full, empty, accept, push, pop;
    wb_source_e               src;
    wb_entry_t                push_entry, head;
    logic [NUM_REGISTERS-1:0] pending, pending_nxt;

    // Fixed priority mem > md > alu; readiness ignores any same-cycle pop.
    assign bus.mem_ready = !rst && !full;
    assign bus.md_ready  = !rst && !full && !bus.mem_valid;
    assign bus.alu_ready = !rst && !full && !bus.mem_valid && !bus.md_valid;

    // Pick which source (if any) completes its handshake this cycle.
    always_comb begin
        accept = 1'b0;
        src    = SRC_ALU;
        if (bus.mem_valid && bus.mem_ready) begin
            accept = 1'b1;
            src    = SRC_MEM;
        end else if (bus.md_valid && bus.md_ready) begin
            accept = 1'b1;
            src    = SRC_MULDIV;
        end else if (bus.alu_valid && bus.alu_ready) begin
            accept = 1'b1;
            src    = SRC_ALU;
        end
    end

    // Route the winning source's result into the FIFO entry.
    always_comb begin
        push_entry = '0;
        case (src)
            SRC_MEM:    push_entry = '{sel: bus.mem_sel, data: bus.mem_data};
            SRC_MULDIV: push_entry = '{sel: bus.md_sel,  data: bus.md_data};
            default:    push_entry = '{sel: bus.alu_sel, data: bus.alu_data};
        endcase
    end

    // Results for r0 complete the handshake but are dropped.
    assign push = accept && (push_entry.sel != '0);
    assign pop  = !empty && !bus.wb_hold;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty)
    );

    // Registered write port; sel/data hold when no pop happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.write_en   <= 1'b0;
            bus.write_sel  <= '0;
            bus.write_data <= '0;
        end else begin
            bus.write_en <= pop;
            if (pop) begin
                bus.write_sel  <= head.sel;
                bus.write_data <= head.data;
            end
        end
    end

    // A write in flight frees its register, since write_data is bypassed.
    assign bus.reserve_ok = !pending[bus.reserve_sel] ||
                            write_hits(bus.write_en, bus.write_sel, bus.reserve_sel);

    assign bus.busy_ra = pending[bus.query_sel_ra] &&
                         !write_hits(bus.write_en, bus.write_sel, bus.query_sel_ra);
    assign bus.busy_rb = pending[bus.query_sel_rb] &&
                         !write_hits(bus.write_en, bus.write_sel, bus.query_sel_rb);
    assign bus.busy_rc = pending[bus.query_sel_rc] &&
                         !write_hits(bus.write_en, bus.write_sel, bus.query_sel_rc);

    // Clear on commit first, then set, so a same-edge reservation wins.
    always_comb begin
        pending_nxt = pending;
        if (bus.write_en) pending_nxt[bus.write_sel] = 1'b0;
        if (bus.reserve_en && bus.reserve_ok && (bus.reserve_sel != '0))
            pending_nxt[bus.reserve_sel] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit with a write-order scoreboard.
module tb_reg_writeback_unit;
    import reg_writeback_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_writeback_unit_if bus();

    reg_writeback_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        errors = 0;
    wb_entry_t exp_q[$];
    wb_entry_t mon_e;

    // Every write_en pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && bus.write_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got sel=%0d data=%h expected no write",
                         bus.write_sel, bus.write_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.write_sel !== mon_e.sel || bus.write_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL wb_order got sel=%0d data=%h expected sel=%0d data=%h",
                             bus.write_sel, bus.write_data, mon_e.sel, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    function automatic void expect_wb(sel_t s, data_t d);
        exp_q.push_back('{sel: s, data: d});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.reserve_en = 0; bus.reserve_sel = '0;
        bus.alu_valid = 0; bus.mem_valid = 0; bus.md_valid = 0;
        bus.alu_sel = '0; bus.mem_sel = '0; bus.md_sel = '0;
        bus.alu_data = '0; bus.mem_data = '0; bus.md_data = '0;
        bus.wb_hold = 0;
        bus.query_sel_ra = '0; bus.query_sel_rb = '0; bus.query_sel_rc = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.alu_valid = 1; bus.mem_valid = 1; bus.md_valid = 1;
        bus.query_sel_ra = 5;
        #3;
        checks++;
        if ({bus.mem_ready, bus.md_ready, bus.alu_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready got %b expected 000",
                     {bus.mem_ready, bus.md_ready, bus.alu_ready});
        end
        checks++;
        if (bus.write_en !== 1'b0 || bus.write_sel !== '0 || bus.write_data !== '0) begin
            errors++;
            $display("FAIL reset_write got en=%b sel=%0d data=%h expected 0/0/0",
                     bus.write_en, bus.write_sel, bus.write_data);
        end
        bus.alu_valid = 0; bus.mem_valid = 0; bus.md_valid = 0;
        @(posedge clk);
        #1 rst = 0;
        // Queue three results behind a hold with r5 reserved, then reset.
        bus.wb_hold = 1;
        tick();
        bus.reserve_en = 1; bus.reserve_sel = 5;
        @(negedge clk);
        checks++;
        if (bus.reserve_ok !== 1'b1) begin
            errors++;
            $display("FAIL reset_reserve5 got %b expected 1", bus.reserve_ok);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.reserve_en = 0;
            bus.alu_valid = 1; bus.alu_sel = sel_t'(i + 1); bus.alu_data = 32'h1000_0000 + i;
            @(negedge clk);
            checks++;
            if (bus.alu_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_fill%0d got alu_ready=%b expected 1", i, bus.alu_ready);
            end
        end
        tick();
        bus.alu_valid = 0;
        @(negedge clk);
        checks++;
        if (bus.busy_ra !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy5_before got %b expected 1", bus.busy_ra);
        end
        #2 rst = 1;
        exp_q.delete();
        #1;
        checks++;
        if (bus.write_en !== 1'b0 || bus.busy_ra !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got write_en=%b busy5=%b expected 0/0",
                     bus.write_en, bus.busy_ra);
        end
        @(posedge clk);
        #1 rst = 0;
        bus.wb_hold = 0;
        #1;
        checks++;
        if ({bus.mem_ready, bus.md_ready, bus.alu_ready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready got %b expected 111",
                     {bus.mem_ready, bus.md_ready, bus.alu_ready});
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.write_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard got write_en=%b expected 0", bus.write_en);
        end
    endtask

    task automatic test_priority();
        logic [2:0] exp_rdy [3] = '{3'b100, 3'b110, 3'b111};
        logic       exp_we  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tick();
        bus.mem_valid = 1; bus.mem_sel = 2; bus.mem_data = 32'hA000_0002;
        bus.md_valid  = 1; bus.md_sel  = 3; bus.md_data  = 32'hB000_0003;
        bus.alu_valid = 1; bus.alu_sel = 1; bus.alu_data = 32'hC000_0001;
        expect_wb(2, 32'hA000_0002);
        expect_wb(3, 32'hB000_0003);
        expect_wb(1, 32'hC000_0001);
        for (int c = 0; c < 6; c++) begin
            if (c == 1) bus.mem_valid = 0;
            if (c == 2) bus.md_valid = 0;
            if (c == 3) bus.alu_valid = 0;
            @(negedge clk);
            if (c < 3) begin
                checks++;
                if ({bus.mem_ready, bus.md_ready, bus.alu_ready} !== exp_rdy[c]) begin
                    errors++;
                    $display("FAIL prio_ready%0d got %b expected %b", c,
                             {bus.mem_ready, bus.md_ready, bus.alu_ready}, exp_rdy[c]);
                end
            end
            checks++;
            if (bus.write_en !== exp_we[c]) begin
                errors++;
                $display("FAIL prio_we%0d got %b expected %b", c, bus.write_en, exp_we[c]);
            end
            tick();
        end
    endtask

    task automatic test_scoreboard();
        bus.reserve_en = 1; bus.reserve_sel = 4;
        bus.query_sel_ra = 4; bus.query_sel_rb = 4;
        @(negedge clk);
        checks++;
        if (bus.reserve_ok !== 1'b1 || bus.busy_ra !== 1'b0) begin
            errors++;
            $display("FAIL sb_reserve got ok=%b busy=%b expected 1/0", bus.reserve_ok, bus.busy_ra);
        end
        tick();
        bus.reserve_en = 0;
        bus.alu_valid = 1; bus.alu_sel = 4; bus.alu_data = 32'hDEAD_BEEF;
        expect_wb(4, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (bus.busy_ra !== 1'b1 || bus.busy_rb !== 1'b1 || bus.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL sb_pending got busy_ra=%b busy_rb=%b ready=%b expected 1/1/1",
                     bus.busy_ra, bus.busy_rb, bus.alu_ready);
        end
        tick();
        bus.alu_valid = 0;
        @(negedge clk);
        checks++;
        if (bus.busy_ra !== 1'b1 || bus.write_en !== 1'b0) begin
            errors++;
            $display("FAIL sb_queued got busy=%b we=%b expected 1/0", bus.busy_ra, bus.write_en);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.busy_ra !== 1'b0 || bus.write_en !== 1'b1 || bus.write_sel !== 4'd4) begin
            errors++;
            $display("FAIL sb_bypass got busy=%b we=%b sel=%0d expected 0/1/4",
                     bus.busy_ra, bus.write_en, bus.write_sel);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.busy_ra !== 1'b0 || bus.write_en !== 1'b0) begin
            errors++;
            $display("FAIL sb_cleared got busy=%b we=%b expected 0/0", bus.busy_ra, bus.write_en);
        end
    endtask

    task automatic test_hold();
        int accepted = 0;
        logic exp_r;
        bus.wb_hold = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.alu_valid = 1;
            bus.alu_sel = sel_t'(8 + accepted);
            bus.alu_data = 32'h5000_0000 + accepted;
            @(negedge clk);
            exp_r = (accepted < 4);
            checks++;
            if (bus.alu_ready !== exp_r || bus.write_en !== 1'b0) begin
                errors++;
                $display("FAIL hold_fill%0d got ready=%b we=%b expected %b/0",
                         i, bus.alu_ready, bus.write_en, exp_r);
            end
            if (exp_r) begin
                expect_wb(sel_t'(8 + accepted), 32'h5000_0000 + accepted);
                accepted++;
            end
        end
        tick();
        bus.alu_valid = 0;
        bus.wb_hold = 0;
        @(negedge clk);
        checks++;
        if (bus.alu_ready !== 1'b0 || bus.write_en !== 1'b0) begin
            errors++;
            $display("FAIL hold_full got ready=%b we=%b expected 0/0", bus.alu_ready, bus.write_en);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (bus.write_en !== (k < 4)) begin
                errors++;
                $display("FAIL hold_drain%0d got we=%b expected %b", k, bus.write_en, (k < 4));
            end
        end
    endtask

    task automatic test_reserve_collide();
        tick();
        bus.reserve_en = 1; bus.reserve_sel = 7; bus.query_sel_rc = 7;
        @(negedge clk);
        checks++;
        if (bus.reserve_ok !== 1'b1) begin
            errors++;
            $display("FAIL col_first got ok=%b expected 1", bus.reserve_ok);
        end
        tick();
        bus.alu_valid = 1; bus.alu_sel = 7; bus.alu_data = 32'h0000_7777;
        expect_wb(7, 32'h0000_7777);
        @(negedge clk);
        checks++;
        if (bus.reserve_ok !== 1'b0 || bus.busy_rc !== 1'b1 || bus.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL col_refuse got ok=%b busy=%b ready=%b expected 0/1/1",
                     bus.reserve_ok, bus.busy_rc, bus.alu_ready);
        end
        tick();
        bus.reserve_en = 0; bus.alu_valid = 0;
        tick();
        bus.reserve_en = 1;
        @(negedge clk);
        checks++;
        if (bus.write_en !== 1'b1 || bus.reserve_ok !== 1'b1 || bus.busy_rc !== 1'b0) begin
            errors++;
            $display("FAIL col_same_edge got we=%b ok=%b busy=%b expected 1/1/0",
                     bus.write_en, bus.reserve_ok, bus.busy_rc);
        end
        tick();
        bus.reserve_en = 0;
        @(negedge clk);
        checks++;
        if (bus.busy_rc !== 1'b1) begin
            errors++;
            $display("FAIL col_set_wins got busy=%b expected 1", bus.busy_rc);
        end
        tick();
        bus.alu_valid = 1; bus.alu_sel = 7; bus.alu_data = 32'h0000_7778;
        expect_wb(7, 32'h0000_7778);
        tick();
        bus.alu_valid = 0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (bus.busy_rc !== 1'b0) begin
            errors++;
            $display("FAIL col_cleanup got busy=%b expected 0", bus.busy_rc);
        end
    endtask

    task automatic test_r0();
        tick();
        bus.wb_hold = 1;
        bus.alu_valid = 1; bus.alu_sel = 0; bus.alu_data = 32'h0000_1234;
        bus.reserve_en = 1; bus.reserve_sel = 0; bus.query_sel_ra = 0;
        @(negedge clk);
        checks++;
        if (bus.alu_ready !== 1'b1 || bus.reserve_ok !== 1'b1 || bus.busy_ra !== 1'b0) begin
            errors++;
            $display("FAIL r0_accept got ready=%b ok=%b busy=%b expected 1/1/0",
                     bus.alu_ready, bus.reserve_ok, bus.busy_ra);
        end
        tick();
        bus.reserve_en = 0;
        // r0 took no slot, so four more results still fit before refusal.
        for (int i = 0; i < 5; i++) begin
            bus.alu_sel = sel_t'(2 + i); bus.alu_data = 32'h6000_0000 + i;
            @(negedge clk);
            checks++;
            if (bus.alu_ready !== (i < 4) || bus.busy_ra !== 1'b0 || bus.write_en !== 1'b0) begin
                errors++;
                $display("FAIL r0_fill%0d got ready=%b busy=%b we=%b expected %b/0/0",
                         i, bus.alu_ready, bus.busy_ra, bus.write_en, (i < 4));
            end
            if (i < 4) expect_wb(sel_t'(2 + i), 32'h6000_0000 + i);
            tick();
        end
        bus.alu_valid = 0;
        bus.wb_hold = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.write_en !== (k >= 1 && k <= 4)) begin
                errors++;
                $display("FAIL r0_drain%0d got we=%b expected %b", k, bus.write_en,
                         (k >= 1 && k <= 4));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_scoreboard();
        test_hold();
        test_reserve_collide();
        test_r0();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending writes expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Producer side of the register-file write port: collects results from three execution sources (ALU, load/store, mul/div) through valid/ready handshakes.
- Buffers accepted results in a small FIFO and issues at most one registered write per cycle (write_en/write_sel/write_data) into the register file.
- Keeps a per-register pending scoreboard that decode uses to reserve destinations and to stall on busy operands.

Parameters:
NUM_REGISTERS, 16, architectural registers; r0 is hardwired zero
SEL_WIDTH, 4, register selector width (log2 NUM_REGISTERS)
DATA_WIDTH, 32, register data width
FIFO_DEPTH, 4, writeback buffer entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
reserve_en  in  1  decode requests destination reservation
reserve_sel  in  SEL_WIDTH  register to reserve
reserve_ok  out  1  reservation granted this cycle (combinational)
alu_valid/mem_valid/md_valid  in  1 each  source has a result
alu_ready/mem_ready/md_ready  out  1 each  result accepted at this edge
alu_sel/mem_sel/md_sel  in  SEL_WIDTH each  destination register
alu_data/mem_data/md_data  in  DATA_WIDTH each  result value
wb_hold  in  1  suppress FIFO pop (write port borrowed elsewhere)
query_sel_ra/rb/rc  in  SEL_WIDTH each  decode operand selectors
busy_ra/rb/rc  out  1 each  operand not yet available
write_en  out  1  register-file write enable (registered)
write_sel  out  SEL_WIDTH  register-file write selector (registered)
write_data  out  DATA_WIDTH  register-file write data (registered)

Behaviour:
- Reset (async, any time): FIFO empty, all pending bits 0, write_en=0, write_sel=0, write_data=0, all ready=0 while rst high. In-flight results are discarded.
- Arbitration: fixed priority mem > md > alu. At most one source accepted per cycle.
  - mem_ready = !full.
  - md_ready = !full && !mem_valid.
  - alu_ready = !full && !mem_valid && !md_valid.
  - Transfer occurs when valid && ready at the rising edge.
- Readiness never counts a same-cycle pop. A full FIFO refuses even while popping.
- Accepted result with sel=0: handshake completes, but nothing is pushed.
- Pop: at each edge where the FIFO is non-empty and wb_hold=0, the head moves into the write_* registers and write_en<=1. Otherwise write_en<=0; write_sel/write_data hold their values.
- Latency: result accepted at edge N appears on write_* after edge N+1 when the FIFO was empty and no hold. The register file commits at edge N+2. FIFO order is preserved.
- Scoreboard pending[NUM_REGISTERS]:
  - Set: at an edge where reserve_en && reserve_ok && reserve_sel!=0.
  - Clear: at an edge where write_en=1, for write_sel.
  - Same register set and cleared at the same edge: set wins.
- reserve_ok = !pending[reserve_sel] || (write_en && write_sel==reserve_sel). Reserving r0 always returns ok and sets nothing.
- busy_x = pending[query_sel_x] && !(write_en && write_sel==query_sel_x). Write-in-flight counts as available because the register file bypasses write_data. busy for r0 is always 0.
- Full/empty: count-based occupancy, wrap-around pointers modulo FIFO_DEPTH. Push and pop in the same cycle leave occupancy unchanged.
- A producer writing a register that is not pending is legal; its write simply clears nothing.

Decomposition:
- Package PkgRegWriteback: WbEntry struct {sel, data}; WbSource enum {Alu, Mem, MulDiv}; width constants derived from the parameters.
- Sub-module wb_fifo: synchronous FIFO of WbEntry with push, pop, full, empty and head outputs, same clk/rst.
- Arbitration, scoreboard and output registers stay in reg_writeback_unit.

Test Plan:
- Reset mid-stream with 3 entries queued and r5 pending -> next cycle write_en=0, busy for r5=0, all readies high once rst drops.
- alu_valid, mem_valid and md_valid all high in one cycle (sels 1,2,3) -> mem accepted first, then md, then alu. Writes emerge in order r2, r3, r1 on consecutive cycles.
- reserve r4, then alu writes r4=0xDEADBEEF -> busy_ra(query=4) is 1 until the cycle write_en=1 with write_sel=4, where it is 0. pending clears at that edge.
- wb_hold=1 for 6 cycles with alu streaming -> exactly 4 accepted, then alu_ready=0. Release hold -> 4 writes on 4 consecutive cycles.
- reserve_en on r7 in the same cycle write_en=1 with write_sel=7 -> reserve_ok=1 and r7 stays pending after the edge.
- alu result to r0 with value 0x1234 -> alu_ready=1, no write_en pulse, no FIFO occupancy change. reserve of r0 -> reserve_ok=1, busy stays 0.
